fp_div_result_queue: RTL and testbench

- Downstream companion to the 32-bit pipelined FP divider. The divider has a fixed latency, a go/done trigger pair, and no stall input.
- This block captures every divider result in a first-word-fall-through FIFO and presents it to the consumer with a valid/ready handshake.
- It tracks in-flight operations as credits. The issue logic upstream of the divider may assert go only while can_issue is high, so no result is ever lost.

---
 rtl/fp_div_result_queue.sv | 120 ++++++++++++
 tb/tb_fp_div_result_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_result_queue.sv
// Result queue behind the fixed-latency FP divider: first-word-fall-through
// FIFO with valid/ready output and in-flight credit tracking for the issuer.
module fp_div_result_queue #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               issue_go,
  output logic                               can_issue,
  input  logic                               res_valid,
  input  logic [DATA_WIDTH-1:0]              res_data,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  input  logic                               out_ready,
  output logic [$clog2(DEPTH+1)-1:0]         occupancy,
  output logic [$clog2(DEPTH+1)-1:0]         inflight,
  output logic                               err_overflow,
  output logic                               err_spurious
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [CW-1:0]         infl_q, infl_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  can_issue_q, can_issue_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_spur_q, err_spur_d;
  logic                  pop, push;

  // Next-state: push/pop decisions, counters, sticky errors, and the
  // registered head/credit view derived from next-cycle state.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    infl_d      = infl_q;
    err_ovf_d   = err_ovf_q;
    err_spur_d  = err_spur_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    can_issue_d = 1'b1;

    pop  = out_valid_q && out_ready;
    // A full FIFO still accepts a result when the head leaves this cycle.
    push = res_valid && ((occ_q != DEPTH_C) || pop);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      occ_d = occ_q + CW'(1);
    else if (pop && !push) occ_d = occ_q - CW'(1);

    // Issue and return in the same cycle cancel; otherwise saturate at both ends.
    if (issue_go && !res_valid) begin
      if (infl_q != DEPTH_C) infl_d = infl_q + CW'(1);
    end else if (res_valid && !issue_go) begin
      if (infl_q != '0) infl_d = infl_q - CW'(1);
    end

    if (res_valid && !push)         err_ovf_d  = 1'b1;
    if (res_valid && infl_q == '0)  err_spur_d = 1'b1;

    can_issue_d = (SW'(occ_d) + SW'(infl_d)) < SW'(DEPTH);
    out_valid_d = (occ_d != '0);

    // Head slot being written this cycle must be forwarded, storage is not yet updated.
    if (!out_valid_d)                        out_data_d = '0;
    else if (push && (wr_ptr_q == rd_ptr_d)) out_data_d = res_data;
    else                                     out_data_d = mem_q[rd_ptr_d];
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      infl_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      can_issue_q <= 1'b1;
      err_ovf_q   <= 1'b0;
      err_spur_q  <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      infl_q      <= infl_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      can_issue_q <= can_issue_d;
      err_ovf_q   <= err_ovf_d;
      err_spur_q  <= err_spur_d;
    end
  end

  // Result storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= res_data;
  end

  assign can_issue    = can_issue_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign occupancy    = occ_q;
  assign inflight     = infl_q;
  assign err_overflow = err_ovf_q;
  assign err_spurious = err_spur_q;

endmodule

// File: tb/tb_fp_div_result_queue.sv
// Directed bench for fp_div_result_queue with a fixed-latency divider model.
module tb_fp_div_result_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 5;
  localparam int          LAT   = 14;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          issue_go = 1'b0;
  logic          can_issue;
  logic          res_valid = 1'b0;
  logic [DW-1:0] res_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] inflight;
  logic          err_overflow;
  logic          err_spurious;

  fp_div_result_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_go    (issue_go),
    .can_issue   (can_issue),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .occupancy   (occupancy),
    .inflight    (inflight),
    .err_overflow(err_overflow),
    .err_spurious(err_spurious)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int          due_q[$];
  logic [31:0] dat_q[$];

  typedef struct {
    logic        go, rv;
    logic [31:0] rd;
    logic        rdy;
    logic        ci, ov;
    logic [31:0] od;
    logic [4:0]  occ, inf;
    logic        eo, es;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // One cycle with explicit divider-side inputs; reports whether the head left.
  task automatic raw(input logic go, input logic rv, input logic [31:0] rd, input logic rdy,
                     output logic popped, output logic [31:0] pd);
    issue_go  = go;
    res_valid = rv;
    res_data  = rd;
    out_ready = rdy;
    popped    = out_valid && rdy;
    pd        = out_data;
    step();
    issue_go  = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
  endtask

  // One cycle through the divider model: results return LAT cycles after issue.
  task automatic drive(input logic go, input logic [31:0] gd, input logic rdy,
                       output logic popped, output logic [31:0] pd);
    logic        rv;
    logic [31:0] rd;
    rv = 1'b0;
    rd = '0;
    if (go) begin
      due_q.push_back(cyc + LAT);
      dat_q.push_back(gd);
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      rv = 1'b1;
      rd = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    raw(go, rv, rd, rdy, popped, pd);
  endtask

  task automatic do_reset();
    issue_go  = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    due_q.delete();
    dat_q.delete();
    step();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        p;
    logic [31:0] d;
    int issued, first_low, sent, rcv, maxocc, ci_low;

    // go rv rd rdy | ci ov od occ inf eo es
    vt[0] = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 5'd1, 5'd0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h11, 5'd1, 5'd1, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h11, 5'd1, 5'd2, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22, 5'd1, 5'd1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 32'h22, 5'd2, 5'd1, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 32'h33, 5'd2, 5'd0, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h44, 5'd1, 5'd0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 5'd0, 5'd0, 1'b0, 1'b1};
    vt[8] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 5'd0, 5'd0, 1'b0, 1'b1};

    // Reset state and a single operation.
    do_reset();
    chk("rst_can_issue", can_issue, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err_overflow", err_overflow, 0);
    chk("rst_err_spurious", err_spurious, 0);
    drive(1'b1, 32'h40490FDB, 1'b0, p, d);
    chk("single_inflight_1", inflight, 1);
    while (cyc < LAT) drive(1'b0, 0, 1'b0, p, d);
    chk("single_not_early", out_valid, 0);
    drive(1'b0, 0, 1'b0, p, d);
    chk("single_inflight_0", inflight, 0);
    chk("single_out_valid", out_valid, 1);
    chk("single_out_data", out_data, 32'h40490FDB);
    chk("single_occupancy", occupancy, 1);
    drive(1'b0, 0, 1'b1, p, d);
    chk("single_popped", {31'd0, p}, 1);
    chk("single_pop_data", d, 32'h40490FDB);
    chk("single_occ_after", occupancy, 0);
    chk("single_data_zero", out_data, 0);

    // Backpressure fill then in-order drain.
    do_reset();
    issued = 0;
    first_low = -1;
    for (int i = 0; i < 60; i++) begin
      if (!can_issue && first_low < 0) first_low = issued;
      if (can_issue) begin
        drive(1'b1, 32'(issued + 1), 1'b0, p, d);
        issued++;
      end else begin
        drive(1'b0, 0, 1'b0, p, d);
      end
    end
    chk("fill_first_low", 32'(first_low), 16);
    chk("fill_issued", 32'(issued), 16);
    chk("fill_occupancy", occupancy, 16);
    chk("fill_inflight", inflight, 0);
    chk("fill_err_overflow", err_overflow, 0);
    chk("fill_can_issue", can_issue, 0);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 32'(i));
      drive(1'b0, 0, 1'b1, p, d);
      if (i == 1) chk("drain_credit_back", can_issue, 1);
    end
    chk("drain_occupancy", occupancy, 0);
    chk("drain_out_valid", out_valid, 0);

    // Streaming with the consumer always ready.
    do_reset();
    sent = 0; rcv = 0; maxocc = 0; ci_low = 0;
    for (int i = 0; i < 130; i++) begin
      if (!can_issue) ci_low++;
      if (sent < 100) begin
        drive(1'b1, 32'h1000 + 32'(sent), 1'b1, p, d);
        sent++;
      end else begin
        drive(1'b0, 0, 1'b1, p, d);
      end
      if (p) begin
        chk("stream_order", d, 32'h1000 + 32'(rcv));
        rcv++;
      end
      if (int'(occupancy) > maxocc) maxocc = int'(occupancy);
    end
    chk("stream_can_issue_low", 32'(ci_low), 0);
    chk("stream_received", 32'(rcv), 100);
    chk("stream_max_occ_le1", {31'd0, maxocc <= 1}, 1);
    chk("stream_inflight", inflight, 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 32'(i + 1), 1'b0, p, d);
    for (int i = 0; i < 20; i++) drive(1'b0, 0, 1'b0, p, d);
    chk("full_occ", occupancy, 16);
    raw(1'b0, 1'b1, 32'hAAAA0001, 1'b1, p, d);
    chk("full_pp_pop_data", d, 1);
    chk("full_pp_occ", occupancy, 16);
    chk("full_pp_overflow", err_overflow, 0);
    chk("full_pp_spurious", err_spurious, 1);
    chk("full_pp_can_issue", can_issue, 0);
    for (int i = 2; i <= 17; i++) begin
      chk("full_pp_drain", out_data, (i == 17) ? 32'hAAAA0001 : 32'(i));
      raw(1'b0, 1'b0, 0, 1'b1, p, d);
    end
    chk("full_pp_empty", occupancy, 0);

    // Table-driven vectors: spurious result, mixed issue/return/pop.
    do_reset();
    foreach (vt[k]) begin
      raw(vt[k].go, vt[k].rv, vt[k].rd, vt[k].rdy, p, d);
      chk($sformatf("vec%0d_can_issue", k), can_issue, vt[k].ci);
      chk($sformatf("vec%0d_out_valid", k), out_valid, vt[k].ov);
      chk($sformatf("vec%0d_out_data", k), out_data, vt[k].od);
      chk($sformatf("vec%0d_occupancy", k), occupancy, vt[k].occ);
      chk($sformatf("vec%0d_inflight", k), inflight, vt[k].inf);
      chk($sformatf("vec%0d_err_overflow", k), err_overflow, vt[k].eo);
      chk($sformatf("vec%0d_err_spurious", k), err_spurious, vt[k].es);
    end

    // Overflow drops data and both flags stay sticky until reset.
    for (int i = 0; i < 16; i++) raw(1'b0, 1'b1, 32'h500 + 32'(i), 1'b0, p, d);
    chk("ovf_pre_occ", occupancy, 16);
    chk("ovf_pre_flag", err_overflow, 0);
    raw(1'b0, 1'b1, 32'hDEAD, 1'b0, p, d);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_occ", occupancy, 16);
    chk("ovf_head", out_data, 32'h500);
    for (int i = 0; i < 5; i++) raw(1'b0, 1'b0, 0, 1'b0, p, d);
    chk("ovf_sticky", err_overflow, 1);
    chk("spur_sticky", err_spurious, 1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", out_data, 32'h500 + 32'(i));
      raw(1'b0, 1'b0, 0, 1'b1, p, d);
    end
    chk("ovf_dropped_empty", occupancy, 0);
    do_reset();
    chk("flags_clear_ovf", err_overflow, 0);
    chk("flags_clear_spur", err_spurious, 0);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 5; i++) raw(1'b0, 1'b1, 32'h600 + 32'(i), 1'b0, p, d);
    for (int i = 0; i < 7; i++) raw(1'b1, 1'b0, 0, 1'b0, p, d);
    chk("arst_pre_occ", occupancy, 5);
    chk("arst_pre_inflight", inflight, 7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_can_issue", can_issue, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_inflight", inflight, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("arst_post_occ", occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
